// File: rtl/dsp_mac_pkg.sv
// dsp_mac_pkg: shared OPMODE constants, sequencer state and pipeline tag types
package dsp_mac_pkg;
  localparam logic [7:0] OPMODE_FIRST = 8'h1E;
  localparam logic [7:0] OPMODE_ACC = 8'h16;
  typedef enum logic {FIRST, ACCUM} state_t;
  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } tag_t;
endpackage

// File: rtl/dsp_mac_resbuf.sv
// dsp_mac_resbuf: 2-entry result FIFO (clk, RST, push/push_data, pop, head/valid/occ)
module dsp_mac_resbuf #(
  parameter int W = 48
) (
  input  logic         clk,
  input  logic         RST,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         valid,
  output logic [1:0]   occ
);
  logic [W-1:0] mem [2];
  logic wr_ptr, rd_ptr;
  always_ff @(posedge clk) begin
    if (RST) begin
      mem <= '{default: '0};
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr <= !wr_ptr;
      end
      rd_ptr <= pop ? !rd_ptr : rd_ptr;
      occ <= occ + 2'(push) - 2'(pop);
    end
  end
  always_comb begin
    head = mem[rd_ptr];
    valid = occ != 2'd0;
  end
endmodule

// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer: DSP48A1 dot-product sequencer, res_len port added under DSP_MAC_SEQ_LEN_EN
module dsp_mac_sequencer
  import dsp_mac_pkg::*;
#(
  parameter int MULT_LAT = 2,
  parameter int RES_DEPTH = 2
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [17:0] s_a,
  input  logic [17:0] s_b,
  input  logic        s_last,
  output logic [17:0] dsp_A,
  output logic [17:0] dsp_B,
  output logic        dsp_CEAB,
  output logic        dsp_CEM,
  output logic        dsp_CEP,
  output logic [7:0]  dsp_OPMODE,
  output logic        dsp_RST,
  input  logic [47:0] dsp_P,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [47:0] res_data
`ifdef DSP_MAC_SEQ_LEN_EN
  ,
  output logic [15:0] res_len
`endif
);
`ifdef DSP_MAC_SEQ_LEN_EN
  localparam int W = 64;
`else
  localparam int W = 48;
`endif
  state_t state, state_n;
  tag_t st [MULT_LAT+2];
  tag_t acc_tag, op_tag;
  logic accept, cap, pop;
  logic [1:0] occ;
  logic [3:0] pending;
  logic [W-1:0] push_data, head;
  always_comb begin
    accept = s_valid && s_ready;
    acc_tag = {accept, state == FIRST, s_last};
    state_n = accept ? (s_last ? FIRST : ACCUM) : state;
    cap = st[MULT_LAT+1].valid && st[MULT_LAT+1].last;
    pop = res_valid && res_ready;
    pending = 4'(occ);
    for (int k = 0; k <= MULT_LAT + 1; k++) pending = pending + 4'(st[k].valid && st[k].last);
    s_ready = !RST && !dsp_RST && pending < 4'(RES_DEPTH);
  end
  if (MULT_LAT == 1) begin : g_op
    assign op_tag = acc_tag;
  end else begin : g_op
    assign op_tag = st[MULT_LAT-2];
  end
  always_ff @(posedge clk) state <= RST ? FIRST : state_n;
  always_ff @(posedge clk) begin
    if (RST) begin
      st <= '{default: '0};
      dsp_A <= '0;
      dsp_B <= '0;
      dsp_CEAB <= 1'b0;
      dsp_CEM <= 1'b0;
      dsp_CEP <= 1'b0;
      dsp_OPMODE <= 8'h00;
      dsp_RST <= 1'b1;
    end else begin
      st[0] <= acc_tag;
      for (int k = 1; k <= MULT_LAT + 1; k++) st[k] <= st[k-1];
      dsp_A <= accept ? s_a : dsp_A;
      dsp_B <= accept ? s_b : dsp_B;
      dsp_CEAB <= accept;
      dsp_CEM <= 1'b1;
      dsp_CEP <= st[MULT_LAT-1].valid;
      dsp_OPMODE <= op_tag.valid ? (op_tag.first ? OPMODE_FIRST : OPMODE_ACC) : dsp_OPMODE;
      dsp_RST <= 1'b0;
    end
  end
`ifdef DSP_MAC_SEQ_LEN_EN
  logic [15:0] len_q;
  always_ff @(posedge clk) begin
    if (RST) len_q <= '0;
    else if (st[MULT_LAT].valid) len_q <= st[MULT_LAT].first ? 16'd1 : (&len_q ? len_q : len_q + 16'd1);
  end
  always_comb begin
    push_data = {len_q, dsp_P};
    res_data = head[47:0];
    res_len = head[63:48];
  end
`else
  always_comb begin
    push_data = dsp_P;
    res_data = head;
  end
`endif
  dsp_mac_resbuf #(.W(W)) u_resbuf (
    .clk(clk),
    .RST(RST),
    .push(cap),
    .push_data(push_data),
    .pop(pop),
    .head(head),
    .valid(res_valid),
    .occ(occ)
  );
endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// tb_dsp_mac_sequencer: directed bench with a DSP48A1 slice model behind the sequencer
module tb_dsp_mac_sequencer;
  logic clk = 1'b0;
  logic RST, s_valid, s_ready, s_last, dsp_CEAB, dsp_CEM, dsp_CEP, dsp_RST;
  logic res_valid, res_ready, cep_clr;
  logic [17:0] s_a, s_b, dsp_A, dsp_B, a1, b1;
  logic [7:0] dsp_OPMODE, op;
  logic [47:0] dsp_P, res_data, m, p;
  int checks = 0;
  int errors = 0;
  int cep_cnt;
  int n_res;
  logic [47:0] last_res;
`ifdef DSP_MAC_SEQ_LEN_EN
  logic [15:0] res_len;
`endif
  always #5 clk = ~clk;
  dsp_mac_sequencer dut (
    .clk(clk),
    .RST(RST),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_a(s_a),
    .s_b(s_b),
    .s_last(s_last),
    .dsp_A(dsp_A),
    .dsp_B(dsp_B),
    .dsp_CEAB(dsp_CEAB),
    .dsp_CEM(dsp_CEM),
    .dsp_CEP(dsp_CEP),
    .dsp_OPMODE(dsp_OPMODE),
    .dsp_RST(dsp_RST),
    .dsp_P(dsp_P),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data(res_data)
`ifdef DSP_MAC_SEQ_LEN_EN
    ,
    .res_len(res_len)
`endif
  );
  always_ff @(posedge clk) begin
    if (dsp_RST) begin
      a1 <= '0;
      b1 <= '0;
      m <= '0;
      op <= '0;
      p <= '0;
    end else begin
      if (dsp_CEAB) begin
        a1 <= dsp_A;
        b1 <= dsp_B;
      end
      if (dsp_CEM) m <= 48'(a1) * 48'(b1);
      op <= dsp_OPMODE;
      if (dsp_CEP) p <= (op == 8'h1E) ? m : ((op == 8'h16) ? p + m : p);
    end
  end
  assign dsp_P = p;
  always @(negedge clk) cep_cnt <= cep_clr ? 0 : cep_cnt + int'(dsp_CEP);
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [17:0] a, input logic [17:0] b, input logic last);
    s_valid = 1'b1;
    s_a = a;
    s_b = b;
    s_last = last;
    @(negedge clk);
    chk("s_ready_on_send", s_ready, 1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask
  task automatic wait_res(input int max);
    int n = 0;
    while (!res_valid && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("res_valid_timeout", 64'(n < max), 1);
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    RST = 1'b1;
    s_valid = 1'b0;
    s_a = '0;
    s_b = '0;
    s_last = 1'b0;
    res_ready = 1'b1;
    cep_clr = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_ceab", dsp_CEAB, 0);
    chk("rst_cem", dsp_CEM, 0);
    chk("rst_cep", dsp_CEP, 0);
    chk("rst_opmode", dsp_OPMODE, 8'h00);
    chk("rst_a", dsp_A, 0);
    chk("rst_b", dsp_B, 0);
    chk("rst_dsp_rst", dsp_RST, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    @(posedge clk);
    #1;
    RST = 1'b0;
    @(negedge clk);
    chk("post_rst1_s_ready", s_ready, 0);
    chk("post_rst1_dsp_rst", dsp_RST, 1);
    @(negedge clk);
    chk("post_rst2_s_ready", s_ready, 1);
    chk("post_rst2_dsp_rst", dsp_RST, 0);
    chk("post_rst2_cem", dsp_CEM, 1);
    @(posedge clk);
    #1;
    send(18'd2, 18'd3, 1'b0);
    send(18'd4, 18'd5, 1'b0);
    send(18'd6, 18'd7, 1'b1);
    repeat (4) @(negedge clk);
    chk("vec3_not_early", res_valid, 0);
    @(negedge clk);
    chk("vec3_valid_t5", res_valid, 1);
    chk("vec3_data", res_data, 48'h44);
`ifdef DSP_MAC_SEQ_LEN_EN
    chk("vec3_len", res_len, 16'd3);
`endif
    @(negedge clk);
    chk("vec3_popped", res_valid, 0);
    idle(1);
    send(18'h3FFFF, 18'h3FFFF, 1'b1);
    @(negedge clk);
    chk("max_issue_ceab", dsp_CEAB, 1);
    chk("max_issue_a", dsp_A, 18'h3FFFF);
    chk("max_issue_b", dsp_B, 18'h3FFFF);
    @(negedge clk);
    chk("max_ceab_low", dsp_CEAB, 0);
    chk("max_opmode_first", dsp_OPMODE, 8'h1E);
    @(negedge clk);
    chk("max_cep", dsp_CEP, 1);
    wait_res(10);
    chk("max_data", res_data, 48'hFFFF80001);
`ifdef DSP_MAC_SEQ_LEN_EN
    chk("max_len", res_len, 16'd1);
`endif
    idle(3);
    cep_clr = 1'b0;
    send(18'd2, 18'd3, 1'b0);
    idle(1);
    send(18'd4, 18'd5, 1'b0);
    idle(1);
    send(18'd6, 18'd7, 1'b1);
    wait_res(10);
    chk("gap_data", res_data, 48'h44);
    idle(4);
    chk("gap_cep_pulses", 64'(cep_cnt), 3);
    cep_clr = 1'b1;
    res_ready = 1'b0;
    send(18'd1, 18'd1, 1'b1);
    send(18'd2, 18'd2, 1'b1);
    s_valid = 1'b1;
    s_a = 18'd3;
    s_b = 18'd3;
    s_last = 1'b1;
    @(negedge clk);
    chk("full_s_ready_low", s_ready, 0);
    repeat (8) @(negedge clk);
    chk("full_s_ready_held", s_ready, 0);
    chk("full_res_valid", res_valid, 1);
    chk("full_head", res_data, 48'd1);
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    @(negedge clk);
    chk("drain_1", res_data, 48'd1);
    chk("drain_ready_still_low", s_ready, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("drain_4", res_data, 48'd4);
    chk("drain_ready_back", s_ready, 1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    @(negedge clk);
    chk("drain_empty", res_valid, 0);
    wait_res(10);
    chk("drain_9", res_data, 48'd9);
    idle(2);
    send(18'd7, 18'd7, 1'b0);
    send(18'd8, 18'd8, 1'b0);
    RST = 1'b1;
    idle(2);
    RST = 1'b0;
    idle(2);
    send(18'd1, 18'd5, 1'b1);
    n_res = 0;
    last_res = '0;
    repeat (14) begin
      @(negedge clk);
      if (res_valid) begin
        n_res++;
        last_res = res_data;
      end
    end
    chk("rst_mid_count", 64'(n_res), 1);
    chk("rst_mid_data", last_res, 48'd5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
